// File: rtl/timer_device.sv
// timer_device: programmable down-counting timer with one-shot/auto-reload modes and maskable IRQ.
// Word registers at Addr: 0=CTRL{IM,MODE,EN}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
module timer_device #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t             state_q, state_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               en, auto_rl, wr_ctrl, wr_pre;
    assign en      = ctrl_q[0];
    assign auto_rl = ctrl_q[2:1] == 2'b01;
    assign wr_ctrl = WE && Addr == 2'd0;
    assign wr_pre  = WE && Addr == 2'd1;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: state_d = en ? LOAD : IDLE;
            LOAD: begin
                state_d = en ? CNT : IDLE;
                count_d = en ? preset_q : count_q;
            end
            CNT: begin
                state_d = !en ? IDLE : (count_q > CNT_W'(1)) ? CNT : INT;
                count_d = !en ? count_q : (count_q > CNT_W'(1)) ? count_q - CNT_W'(1) : '0;
            end
            default: state_d = (en && auto_rl) ? LOAD : IDLE;
        endcase
        // A CTRL write landing on the INT edge overrides the one-shot EN clear.
        ctrl_d   = wr_ctrl ? DataIn[3:0]
                 : (state_q == INT && !auto_rl) ? {ctrl_q[3:1], 1'b0} : ctrl_q;
        preset_d = wr_pre ? DataIn[CNT_W-1:0] : preset_q;
        irq_d    = (state_q == INT) ? 1'b1
                 : (wr_ctrl || wr_pre || (state_q == LOAD && en)) ? 1'b0 : irq_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end
    always_comb begin
        DataOut = (Addr == 2'd0) ? {28'b0, ctrl_q}
                : (Addr == 2'd1) ? 32'(preset_q)
                : (Addr == 2'd2) ? 32'(count_q) : 32'b0;
    end
    assign IRQ = irq_q & ctrl_q[3];
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed stimulus pushes expected reads into a scoreboard; a negedge monitor pops and compares.
module tb_timer_device;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_d[$];
    logic        exp_irq[$];
    string       exp_tag[$];
    logic [31:0] m_d;
    logic        m_irq;
    string       m_tag;

    timer_device #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
        .DataIn(DataIn), .DataOut(DataOut), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_d.size() > 0) begin
            m_d   = exp_d.pop_front();
            m_irq = exp_irq.pop_front();
            m_tag = exp_tag.pop_front();
            checks++;
            if (DataOut !== m_d || IRQ !== m_irq) begin
                failures++;
                $display("FAIL %s: DataOut=%08h IRQ=%b expected DataOut=%08h IRQ=%b",
                         m_tag, DataOut, IRQ, m_d, m_irq);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a; DataIn = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    // Observes the state left by the most recent edge, then advances one cycle.
    task automatic chk(input logic [1:0] a, input logic [31:0] d, input logic irq, input string tag);
        Addr = a;
        exp_d.push_back(d);
        exp_irq.push_back(irq);
        exp_tag.push_back(tag);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs2[8] = '{0, 0, 5, 4, 3, 2, 1, 0};
        reset = 1'b1; WE = 1'b0; Addr = 2'd0; DataIn = 32'h0;
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) chk(2'(a), 32'h0, 1'b0, $sformatf("reset_addr%0d", a));

        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 8; i++) chk(2'd2, 32'(cs2[i]), 1'b0, $sformatf("oneshot_e%0d", i));
        chk(2'd0, 32'h8, 1'b1, "oneshot_ctrl_irq");
        wr(2'd2, 32'hAB);
        chk(2'd2, 32'h0, 1'b1, "count_write_ignored");
        wr(2'd3, 32'h55);
        chk(2'd0, 32'h8, 1'b1, "reserved_write_sticky");
        wr(2'd0, 32'hFFFF_FFF8);
        chk(2'd0, 32'h8, 1'b0, "ctrl_write_clears");
        chk(2'd3, 32'h0, 1'b0, "reserved_reads_zero");

        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        chk(2'd2, 32'h0, 1'b0, "auto_e0");
        chk(2'd2, 32'h0, 1'b0, "auto_e1");
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 5; k++)
                chk(2'd2, (k < 4) ? 32'(3 - k) : 32'h0, k == 4, $sformatf("auto_p%0d_k%0d", p, k));
        wr(2'd0, 32'h8);
        chk(2'd2, 32'd2, 1'b0, "auto_disable");
        chk(2'd2, 32'd2, 1'b0, "auto_disable_hold");

        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        chk(2'd2, 32'd2, 1'b0, "dis_e0");
        chk(2'd2, 32'd2, 1'b0, "dis_e1");
        chk(2'd2, 32'd10, 1'b0, "dis_e2");
        chk(2'd2, 32'd9, 1'b0, "dis_e3");
        chk(2'd2, 32'd8, 1'b0, "dis_e4");
        wr(2'd0, 32'h8);
        chk(2'd2, 32'd6, 1'b0, "dis_hold0");
        chk(2'd2, 32'd6, 1'b0, "dis_hold1");
        chk(2'd2, 32'd6, 1'b0, "dis_hold2");
        chk(2'd0, 32'h8, 1'b0, "dis_ctrl");
        wr(2'd0, 32'h9);
        chk(2'd2, 32'd6, 1'b0, "reen_e0");
        chk(2'd2, 32'd6, 1'b0, "reen_e1");
        for (int k = 0; k <= 10; k++) chk(2'd2, 32'(10 - k), 1'b0, $sformatf("reen_k%0d", k));
        chk(2'd0, 32'h8, 1'b1, "reen_irq");

        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        chk(2'd2, 32'd0, 1'b0, "mask_e0");
        chk(2'd2, 32'd0, 1'b0, "mask_e1");
        for (int k = 0; k < 5; k++) chk(2'd2, 32'(4 - k), 1'b0, $sformatf("mask_k%0d", k));
        chk(2'd0, 32'h0, 1'b0, "mask_irq_low");
        wr(2'd0, 32'h8);
        chk(2'd0, 32'h8, 1'b0, "mask_then_im");

        wr(2'd1, 32'd9);
        wr(2'd0, 32'hB);
        chk(2'd2, 32'd0, 1'b0, "rst_e0");
        chk(2'd2, 32'd0, 1'b0, "rst_e1");
        chk(2'd2, 32'd9, 1'b0, "rst_e2");
        chk(2'd2, 32'd8, 1'b0, "rst_e3");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) chk(2'(a), 32'h0, 1'b0, $sformatf("midreset_addr%0d", a));
        wr(2'd0, 32'h9);
        chk(2'd2, 32'h0, 1'b0, "p0_e0");
        chk(2'd0, 32'h9, 1'b0, "p0_e1");
        chk(2'd2, 32'h0, 1'b0, "p0_e2");
        chk(2'd0, 32'h9, 1'b0, "p0_e3_int");
        chk(2'd0, 32'h8, 1'b1, "p0_e4_irq");

        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        chk(2'd2, 32'd0, 1'b0, "intwr_e0");
        chk(2'd2, 32'd0, 1'b0, "intwr_e1");
        chk(2'd2, 32'd2, 1'b0, "intwr_e2");
        chk(2'd2, 32'd1, 1'b0, "intwr_e3");
        wr(2'd0, 32'h9);
        chk(2'd0, 32'h9, 1'b1, "intwr_ctrl_wins");
        chk(2'd2, 32'd0, 1'b1, "intwr_load");
        chk(2'd2, 32'd2, 1'b0, "intwr_reload");

        tick(); tick();
        checks++;
        if (exp_d.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected pending=0", exp_d.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
